agc_power_estimator: RTL

//  Upstream feeder of the AGC log stage. Squares an I/Q sample stream and averages I^2+Q^2

---
 rtl/agc_power_estimator_pkg.sv | 37 +++
 rtl/agc_power_estimator_iq_square.sv | 40 ++++
 rtl/agc_power_estimator.sv | 99 +++++++++
 3 files changed

// File: rtl/agc_power_estimator_pkg.sv
// Shared AGC fixed-point definitions: widths, output code limits and the
// saturate/clamp helper used by the power, log and gain stages.
package agc_power_estimator_pkg;

   localparam int W_IQ      = 16;
   localparam int W_SQ      = 2 * W_IQ;
   localparam int W_P       = W_SQ + 1;
   localparam int W_PWR     = 37;
   localparam int FRAC_SQ   = 22;
   localparam int FRAC_PWR  = 28;
   localparam int SCALE_SH  = FRAC_PWR - FRAC_SQ;
   localparam int W_SCALED  = W_P + SCALE_SH;

   localparam logic [W_PWR-1:0] MIN_CODE_DEF = 37'h000041893;
   localparam logic [W_PWR-1:0] MAX_CODE     = {W_PWR{1'b1}};

   typedef struct packed {
      logic [W_SQ-1:0] i_sq;
      logic [W_SQ-1:0] q_sq;
      logic            valid;
   } sq_sample_t;

   // Saturates to the largest code, then lifts tiny values to the log stage's floor.
   function automatic logic [W_PWR-1:0] sat_clamp(input logic [W_SCALED-1:0] v,
                                                  input logic [W_PWR-1:0]    lo);
      logic [W_PWR-1:0] r;
      if (v > W_SCALED'(MAX_CODE)) begin
         r = MAX_CODE;
      end else if (v[W_PWR-1:0] < lo) begin
         r = lo;
      end else begin
         r = v[W_PWR-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/agc_power_estimator_iq_square.sv
// First pipeline stage: registered I^2 and Q^2 (ufix32_En22) plus the sample valid bit.
module agc_power_estimator_iq_square
   import agc_power_estimator_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            enb,
   input  logic            restart,
   input  logic            in_valid,
   input  logic [W_IQ-1:0] in_i,
   input  logic [W_IQ-1:0] in_q,
   output sq_sample_t      sq_q
);

   sq_sample_t             sq_d;
   logic signed [W_IQ-1:0] i_s;
   logic signed [W_IQ-1:0] q_s;
   logic signed [W_SQ-1:0] i_prod;
   logic signed [W_SQ-1:0] q_prod;

   // A squared value is never negative, so the signed product can be reused as unsigned.
   always_comb begin
      i_s         = in_i;
      q_s         = in_q;
      i_prod      = W_SQ'(i_s) * W_SQ'(i_s);
      q_prod      = W_SQ'(q_s) * W_SQ'(q_s);
      sq_d.i_sq   = unsigned'(i_prod);
      sq_d.q_sq   = unsigned'(q_prod);
      sq_d.valid  = in_valid & ~restart;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sq_q <= '0;
      end else if (enb) begin
         sq_q <= sq_d;
      end
   end

endmodule

// File: rtl/agc_power_estimator.sv
// Mean I/Q power over 2^LOG2_N valid samples (accumulate-and-dump), clamped into
// the log stage's ufix37_En28 domain and held between dumps.
module agc_power_estimator
   import agc_power_estimator_pkg::*;
#(
   parameter int               LOG2_N   = 4,
   parameter logic [W_PWR-1:0] MIN_CODE = MIN_CODE_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             enb,
   input  logic             in_valid,
   input  logic [W_IQ-1:0]  In_I,
   input  logic [W_IQ-1:0]  In_Q,
   input  logic             restart,
   output logic [W_PWR-1:0] Out1,
   output logic             out_valid
);

   localparam int                W_ACC    = W_P + LOG2_N;
   localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
   localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

   sq_sample_t          sq_q;
   logic [W_P-1:0]      p;
   logic [W_ACC-1:0]    acc_q, acc_d;
   logic [W_ACC-1:0]    sum_q, sum_d;
   logic [LOG2_N-1:0]   cnt_q, cnt_d;
   logic                dump_q, dump_d;
   logic [W_SCALED-1:0] scaled;
   logic [W_PWR-1:0]    out1_q, out1_d;
   logic                out_valid_q, out_valid_d;

   agc_power_estimator_iq_square u_square (
      .clk      (clk),
      .reset    (reset),
      .enb      (enb),
      .restart  (restart),
      .in_valid (in_valid),
      .in_i     (In_I),
      .in_q     (In_Q),
      .sq_q     (sq_q)
   );

   // Restart wins over both a new sample and a pending dump.
   always_comb begin
      p      = W_P'(sq_q.i_sq) + W_P'(sq_q.q_sq);
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      sum_d  = sum_q;
      dump_d = 1'b0;
      if (restart) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (sq_q.valid) begin
         if (cnt_q == CNT_LAST) begin
            sum_d  = acc_q + W_ACC'(p);
            acc_d  = '0;
            cnt_d  = '0;
            dump_d = 1'b1;
         end else begin
            acc_d = acc_q + W_ACC'(p);
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // Mean is truncated to En22 first, then widened to En28 before the clamp.
   always_comb begin
      scaled      = W_SCALED'(sum_q >> LOG2_N) << SCALE_SH;
      out1_d      = out1_q;
      out_valid_d = dump_q & ~restart;
      if (out_valid_d) begin
         out1_d = sat_clamp(scaled, MIN_CODE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         dump_q      <= 1'b0;
         out1_q      <= MIN_CODE;
         out_valid_q <= 1'b0;
      end else if (enb) begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         dump_q      <= dump_d;
         out1_q      <= out1_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign Out1      = out1_q;
   assign out_valid = out_valid_q;

endmodule
